// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single FIFO_mem write port among NUM_REQ producers, bounded bursts.
// Latency: grant registered one edge after req is sampled in IDLE; the write path is combinational.
// Backpressure: fifo_full stalls the owner indefinitely with grant held; ack only for words actually written.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      fifo_write,
    output logic [DATA_W-1:0]         fifo_din,
    input  logic                      fifo_full
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     ptr_nxt;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     owner_nxt;
    logic [3:0]           burst_cnt;
    logic [3:0]           burst_cnt_nxt;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic [IDX_W-1:0]     pick;
    logic                 pick_vld;
    logic [IDX_W-1:0]     cand;
    logic                 owner_req;
    logic                 release_now;

    // Modulo increment; NUM_REQ need not be a power of two.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (int'(v) == NUM_REQ - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // Scan ptr, ptr+1, ... and keep the first requester found.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_vld && req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
            cand = wrap_inc(cand);
        end
    end

    assign owner_req  = req[owner];
    assign fifo_write = ~rst & (state == GRANT) & owner_req & ~fifo_full;
    assign fifo_din   = req_data[int'(owner)*DATA_W +: DATA_W];
    assign ack        = NUM_REQ'(fifo_write) << owner;
    assign busy       = (state == GRANT);

    // A burst ends on its last permitted word or as soon as the owner withdraws.
    assign release_now = (fifo_write && (burst_cnt == BURST_LAST)) || !owner_req;

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        grant_nxt     = grant;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    owner_nxt     = pick;
                    grant_nxt     = NUM_REQ'(1) << pick;
                    burst_cnt_nxt = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                if (fifo_write) begin
                    burst_cnt_nxt = burst_cnt + 4'd1;
                end
                if (release_now) begin
                    ptr_nxt   = wrap_inc(owner);
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            grant     <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
            grant     <= grant_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues and a FIFO_mem model around the DUT, with a
// transaction-level round-robin model predicting grant order and FIFO contents.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int BL    = 4;
    localparam int DEPTH = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           busy;
    logic           fifo_write;
    logic [W-1:0]   fifo_din;
    logic           fifo_full;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .grant(grant), .busy(busy), .fifo_write(fifo_write), .fifo_din(fifo_din),
        .fifo_full(fifo_full)
    );

    int chk = 0;
    int pass = 0;
    int viol = 0;
    int cyc = 0;
    int mptr = 0;

    logic [W-1:0] pq[N][$];
    logic [W-1:0] exp_w[N][$];
    bit           pen[N];
    logic [W-1:0] fq[$];
    logic [W-1:0] out_q[$];
    bit           rd_en;
    bit           rd_rand;
    int           wlog_src[$];
    logic [W-1:0] wlog_dat[$];
    int           wlog_cyc[$];
    int           gseq[$];
    int           exp_own[$];
    logic [W-1:0] exp_dat[$];
    logic [N-1:0] prev_g;

    task automatic drive();
        req      = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            if (pen[i] && pq[i].size() > 0) begin
                req[i]           = 1'b1;
                req_data[i*W +: W] = pq[i][0];
            end
        end
        fifo_full = (fq.size() >= DEPTH);
        if (rd_rand) rd_en = ($urandom_range(0, 1) == 1);
    endtask

    // One clock: observe at negedge, then apply producer/FIFO effects just after posedge.
    task automatic step();
        logic [N-1:0] s_ack;
        logic         s_wr;
        logic [W-1:0] s_din;
        int           src;
        @(negedge clk);
        s_ack = ack;
        s_wr  = fifo_write;
        s_din = fifo_din;
        src   = -1;
        for (int i = 0; i < N; i++) if (s_ack[i]) src = i;
        if (s_wr) begin
            if (fifo_full || $countones(s_ack) != 1 || s_ack != grant) viol++;
            else if (pq[src].size() == 0 || pq[src][0] !== s_din) viol++;
            wlog_src.push_back(src);
            wlog_dat.push_back(s_din);
            wlog_cyc.push_back(cyc);
        end else if (s_ack != '0) begin
            viol++;
        end
        if (grant != '0 && grant != prev_g)
            for (int i = 0; i < N; i++) if (grant[i]) gseq.push_back(i);
        prev_g = grant;
        @(posedge clk);
        #1;
        if (rd_en && fq.size() > 0) out_q.push_back(fq.pop_front());
        if (s_wr && fq.size() < DEPTH) fq.push_back(s_din);
        for (int i = 0; i < N; i++)
            if (s_ack[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        cyc++;
        drive();
    endtask

    task automatic run_until_idle(input int max_cyc, output bit to);
        bit pend;
        to = 1'b1;
        for (int n = 0; n < max_cyc; n++) begin
            pend = 1'b0;
            for (int i = 0; i < N; i++) if (pen[i] && pq[i].size() > 0) pend = 1'b1;
            if (!pend && grant == '0 && !busy) begin
                to = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic drain();
        rd_rand = 1'b0;
        rd_en   = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (fq.size() == 0) break;
            step();
        end
    endtask

    task automatic load(input int i, input int n, input logic [W-1:0] base, input bit rnd);
        logic [W-1:0] v;
        for (int k = 0; k < n; k++) begin
            v = rnd ? W'($urandom) : base + W'(k);
            pq[i].push_back(v);
            exp_w[i].push_back(v);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            pq[i].delete();
            exp_w[i].delete();
            pen[i] = 1'b1;
        end
        fq.delete(); out_q.delete(); wlog_src.delete(); wlog_dat.delete();
        wlog_cyc.delete(); gseq.delete(); exp_own.delete(); exp_dat.delete();
        rd_rand = 1'b0;
        viol    = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive();
        step();
        step();
        rst    = 1'b0;
        mptr   = 0;
        prev_g = '0;
        drive();
    endtask

    // Grant-level model: round robin from the pointer, each grant takes up to BL words.
    task automatic build_expect();
        int rem[N];
        int pos[N];
        int own;
        int take;
        exp_own.delete();
        exp_dat.delete();
        for (int i = 0; i < N; i++) begin
            rem[i] = exp_w[i].size();
            pos[i] = 0;
        end
        for (int g = 0; g < 1000; g++) begin
            own = -1;
            for (int k = 0; k < N; k++)
                if (own < 0 && rem[(mptr + k) % N] > 0) own = (mptr + k) % N;
            if (own < 0) break;
            take = (rem[own] < BL) ? rem[own] : BL;
            exp_own.push_back(own);
            for (int j = 0; j < take; j++) exp_dat.push_back(exp_w[own][pos[own] + j]);
            pos[own] += take;
            rem[own] -= take;
            mptr = (own + 1) % N;
        end
    endtask

    task automatic test_reset();
        clear_all();
        rst = 1'b1;
        rd_en = 1'b0;
        drive();
        step();
        step();
        chk++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else pass++;
        chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass++;
        chk++; if (fifo_write !== 1'b0) $display("FAIL reset_write: got %b want 0", fifo_write); else pass++;
        chk++; if (ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", ack); else pass++;
        rst = 1'b0;
        prev_g = '0;
        drive();
    endtask

    task automatic test_single();
        bit to;
        logic [W-1:0] e[5];
        e = '{16'h21, 16'h22, 16'h23, 16'h41, 16'h31};
        clear_all();
        rd_en = 1'b0;
        load(2, 3, 16'h21, 1'b0);
        drive();
        step();
        chk++; if (grant !== 4'b0100) $display("FAIL single_grant: got %b want 0100", grant); else pass++;
        run_until_idle(30, to);
        chk++; if (to !== 1'b0) $display("FAIL single_timeout: got %b want 0", to); else pass++;
        chk++; if (wlog_src.size() != 3) $display("FAIL single_count: got %0d want 3", wlog_src.size()); else pass++;
        for (int k = 0; k < 3; k++) begin
            chk++;
            if (wlog_src[k] != 2 || wlog_dat[k] !== 16'h21 + W'(k))
                $display("FAIL single_word%0d: got src %0d data %h want src 2 data %h", k, wlog_src[k], wlog_dat[k], 16'h21 + W'(k));
            else pass++;
        end
        chk++; if (wlog_cyc[2] - wlog_cyc[0] != 2) $display("FAIL single_consec: got span %0d want 2", wlog_cyc[2] - wlog_cyc[0]); else pass++;
        load(0, 1, 16'h31, 1'b0);
        load(3, 1, 16'h41, 1'b0);
        drive();
        step();
        chk++; if (grant !== 4'b1000) $display("FAIL single_ptr3: got %b want 1000", grant); else pass++;
        run_until_idle(30, to);
        drain();
        chk++; if (out_q.size() != 5) $display("FAIL single_fifo_count: got %0d want 5", out_q.size()); else pass++;
        for (int k = 0; k < 5; k++) begin
            chk++; if (out_q[k] !== e[k]) $display("FAIL single_fifo%0d: got %h want %h", k, out_q[k], e[k]); else pass++;
        end
    endtask

    task automatic test_contention();
        bit to;
        int bad;
        clear_all();
        do_reset();
        rd_en = 1'b1;
        for (int i = 0; i < N; i++) load(i, 8, W'(i * 16), 1'b0);
        drive();
        build_expect();
        run_until_idle(200, to);
        drain();
        chk++; if (to !== 1'b0) $display("FAIL cont_timeout: got %b want 0", to); else pass++;
        chk++; if (gseq.size() != 8) $display("FAIL cont_grants: got %0d want 8", gseq.size()); else pass++;
        for (int k = 0; k < 8; k++) begin
            chk++; if (gseq[k] != exp_own[k]) $display("FAIL cont_order%0d: got %0d want %0d", k, gseq[k], exp_own[k]); else pass++;
        end
        bad = 0;
        for (int k = 0; k < 32; k++) if (out_q[k] !== exp_dat[k]) bad++;
        chk++; if (out_q.size() != 32 || bad != 0) $display("FAIL cont_data: got %0d words %0d wrong want 32 words 0 wrong", out_q.size(), bad); else pass++;
        chk++;
        if (wlog_cyc[31] - wlog_cyc[0] != 8 * (BL + 1) - 2)
            $display("FAIL cont_span: got %0d want %0d", wlog_cyc[31] - wlog_cyc[0], 8 * (BL + 1) - 2);
        else pass++;
        chk++; if (viol != 0) $display("FAIL cont_protocol: got %0d violations want 0", viol); else pass++;
    endtask

    task automatic test_stall();
        bit to;
        int bad;
        clear_all();
        do_reset();
        rd_en = 1'b0;
        load(0, 10, 16'h00, 1'b0);
        drive();
        for (int n = 0; n < 40; n++) begin
            if (wlog_src.size() >= 7) break;
            step();
        end
        step(); step(); step();
        chk++; if (wlog_src.size() != 7) $display("FAIL stall_acks: got %0d want 7", wlog_src.size()); else pass++;
        chk++; if (fifo_write !== 1'b0 || ack !== 4'b0000) $display("FAIL stall_write: got write %b ack %b want 0 0000", fifo_write, ack); else pass++;
        chk++; if (grant !== 4'b0001) $display("FAIL stall_grant: got %b want 0001", grant); else pass++;
        rd_en = 1'b1;
        run_until_idle(100, to);
        drain();
        chk++; if (to !== 1'b0) $display("FAIL stall_timeout: got %b want 0", to); else pass++;
        chk++; if (wlog_dat[7] !== 16'h07) $display("FAIL stall_resume: got %h want 0007", wlog_dat[7]); else pass++;
        bad = 0;
        for (int k = 0; k < 10; k++) if (out_q[k] !== W'(k)) bad++;
        chk++; if (out_q.size() != 10 || bad != 0) $display("FAIL stall_data: got %0d words %0d wrong want 10 words 0 wrong", out_q.size(), bad); else pass++;
        chk++; if (viol != 0) $display("FAIL stall_protocol: got %0d violations want 0", viol); else pass++;
    endtask

    task automatic test_early_drop();
        bit to;
        logic [W-1:0] e[5];
        e = '{16'h50, 16'h51, 16'h60, 16'h52, 16'h53};
        clear_all();
        do_reset();
        rd_en = 1'b1;
        load(1, 4, 16'h50, 1'b0);
        drive();
        for (int n = 0; n < 20; n++) begin
            if (wlog_src.size() >= 2) break;
            step();
        end
        pen[1] = 1'b0;
        drive();
        step();
        chk++; if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL drop_release: got grant %b busy %b want 0000 0", grant, busy); else pass++;
        chk++; if (wlog_src.size() != 2) $display("FAIL drop_acks: got %0d want 2", wlog_src.size()); else pass++;
        load(2, 1, 16'h60, 1'b0);
        pen[1] = 1'b1;
        drive();
        step();
        chk++; if (grant !== 4'b0100) $display("FAIL drop_next: got %b want 0100", grant); else pass++;
        run_until_idle(50, to);
        drain();
        chk++; if (out_q.size() != 5) $display("FAIL drop_count: got %0d want 5", out_q.size()); else pass++;
        for (int k = 0; k < 5; k++) begin
            chk++; if (out_q[k] !== e[k]) $display("FAIL drop_fifo%0d: got %h want %h", k, out_q[k], e[k]); else pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [W-1:0] e[4];
        e = '{16'h70, 16'h80, 16'h71, 16'h72};
        clear_all();
        do_reset();
        rd_en = 1'b1;
        load(3, 3, 16'h70, 1'b0);
        drive();
        for (int n = 0; n < 20; n++) begin
            if (wlog_src.size() >= 1) break;
            step();
        end
        rst = 1'b1;
        #1;
        chk++; if (fifo_write !== 1'b0 || ack !== 4'b0000) $display("FAIL rstmid_write: got write %b ack %b want 0 0000", fifo_write, ack); else pass++;
        step();
        chk++; if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL rstmid_state: got grant %b busy %b want 0000 0", grant, busy); else pass++;
        rst = 1'b0;
        load(0, 1, 16'h80, 1'b0);
        drive();
        step();
        chk++; if (grant !== 4'b0001) $display("FAIL rstmid_ptr0: got %b want 0001", grant); else pass++;
        run_until_idle(50, to);
        drain();
        chk++; if (out_q.size() != 4) $display("FAIL rstmid_count: got %0d want 4", out_q.size()); else pass++;
        for (int k = 0; k < 4; k++) begin
            chk++; if (out_q[k] !== e[k]) $display("FAIL rstmid_fifo%0d: got %h want %h", k, out_q[k], e[k]); else pass++;
        end
    endtask

    task automatic test_tie();
        bit to;
        clear_all();
        do_reset();
        rd_en = 1'b1;
        load(1, 1, 16'h90, 1'b0);
        drive();
        run_until_idle(30, to);
        gseq.delete();
        load(1, 1, 16'h91, 1'b0);
        load(3, 1, 16'h93, 1'b0);
        drive();
        step();
        chk++; if (grant !== 4'b1000) $display("FAIL tie_first: got %b want 1000", grant); else pass++;
        run_until_idle(30, to);
        chk++; if (gseq.size() != 2 || gseq[1] != 1) $display("FAIL tie_second: got %0d grants last %0d want 2 grants last 1", gseq.size(), gseq[1]); else pass++;
    endtask

    task automatic test_random();
        bit to;
        int bad;
        for (int it = 0; it < 4; it++) begin
            clear_all();
            do_reset();
            rd_rand = 1'b1;
            for (int i = 0; i < N; i++) load(i, $urandom_range(0, 10), '0, 1'b1);
            drive();
            build_expect();
            run_until_idle(800, to);
            drain();
            chk++; if (to !== 1'b0) $display("FAIL rand%0d_timeout: got %b want 0", it, to); else pass++;
            bad = 0;
            for (int k = 0; k < exp_own.size(); k++) if (gseq[k] != exp_own[k]) bad++;
            chk++; if (gseq.size() != exp_own.size() || bad != 0) $display("FAIL rand%0d_grants: got %0d grants %0d wrong want %0d grants 0 wrong", it, gseq.size(), bad, exp_own.size()); else pass++;
            bad = 0;
            for (int k = 0; k < exp_dat.size(); k++) if (out_q[k] !== exp_dat[k]) bad++;
            chk++; if (out_q.size() != exp_dat.size() || bad != 0) $display("FAIL rand%0d_data: got %0d words %0d wrong want %0d words 0 wrong", it, out_q.size(), bad, exp_dat.size()); else pass++;
            chk++; if (viol != 0) $display("FAIL rand%0d_protocol: got %0d violations want 0", it, viol); else pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_en = 1'b0;
        rd_rand = 1'b0;
        prev_g = '0;
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_early_drop();
        test_reset_mid();
        test_tie();
        test_random();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", pass, chk);
        $fatal(1);
    end

endmodule
